pc_gen: RTL

- Fetch-address generator for the IF stage. It sits directly downstream of the branch prediction unit and upstream of the instruction-memory request port.
- Holds the architectural fetch PC and issues one fetch request per accepted handshake.
- Selects the next PC by priority: pipeline flush target, BPU correction target, BPU predicted-taken target (after the delay slot), PC+4.
- Drives correct_finish back to the BPU, closing its CORRECTION state.

---
 rtl/pc_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: owns the fetch PC and picks the next PC.
// Redirect priority: pipeline flush, BPU correction, BPU taken prediction, then sequential PC+4.
package pc_gen_pkg;
    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
    } pipeline_flush_t;
endpackage

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  pipeline_flush_t pipeline_flush,
    input  logic [PC_W-1:0] flush_target,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic [PC_W-1:0] pred_pc,
    input  logic            bpu_flush,
    input  logic            is_correction,
    input  logic [PC_W-1:0] correct_target,
    output logic            correct_finish,
    output logic            inst_req,
    output logic [PC_W-1:0] inst_addr,
    input  logic            inst_addr_ok,
    output logic            fs_flush
);

    typedef enum logic [1:0] {RUN, SLOT, HOLD, CORR} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pend_target;
    logic            accept;
    logic            any_flush;
    logic            pred_hit;

    localparam logic [PC_W-1:0] STEP = PC_W'(4);

    assign accept    = inst_req && inst_addr_ok;
    assign any_flush = |pipeline_flush;
    assign pred_hit  = pred_valid && pred_taken;
    assign inst_addr = (state == CORR) ? correct_target : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            state          <= RUN;
            inst_req       <= 1'b0;
            correct_finish <= 1'b0;
            fs_flush       <= 1'b0;
            pend_target    <= '0;
        end else begin
            correct_finish <= 1'b0;
            fs_flush       <= 1'b0;
            if (any_flush) begin
                pc          <= flush_target;
                state       <= RUN;
                pend_target <= '0;
                fs_flush    <= 1'b1;
                inst_req    <= 1'b1;
            end else begin
                case (state)
                    RUN, SLOT: begin
                        // The BPU leaves CORRECTION on the edge that samples correct_finish,
                        // so its is_correction is still high during that cycle and must be ignored.
                        if (is_correction && !correct_finish) begin
                            state       <= CORR;
                            pend_target <= '0;
                            inst_req    <= 1'b1;
                        end else if (bpu_flush) begin
                            state       <= HOLD;
                            pend_target <= '0;
                            inst_req    <= inst_req && !inst_addr_ok;
                        end else if (state == SLOT) begin
                            inst_req <= 1'b1;
                            if (accept) begin
                                pc    <= pend_target;
                                state <= RUN;
                            end
                        end else if (pred_hit) begin
                            inst_req    <= 1'b1;
                            pend_target <= pred_target;
                            if (pc == pred_pc + STEP) begin
                                if (accept) pc <= pred_target;
                                else        state <= SLOT;
                            end else begin
                                // Delay slot already went out; anything fetched past it is wrong-path.
                                pc       <= pred_target;
                                fs_flush <= 1'b1;
                            end
                        end else begin
                            inst_req <= 1'b1;
                            if (accept) pc <= pc + STEP;
                        end
                    end
                    HOLD: begin
                        if (is_correction) begin
                            state    <= CORR;
                            inst_req <= 1'b1;
                        end else if (accept) begin
                            inst_req <= 1'b0;
                        end
                    end
                    CORR: begin
                        inst_req <= 1'b1;
                        if (accept) begin
                            pc             <= correct_target + STEP;
                            state          <= RUN;
                            correct_finish <= 1'b1;
                            fs_flush       <= 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule
